yacc_dport_arbiter: RTL

//  Shares the single data port of the yacc RAM module (Daddr/wren/datain/access_mode -> MOUT)

---
 rtl/yacc_dport_if.sv | 53 +++++
 rtl/yacc_dport_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/yacc_dport_if.sv
// Bundle for the shared yacc RAM data port: CPU side, host requester side and RAM side.
// DPORT_BURST_EN adds host_len (beats-1) for multi-beat host bursts.
interface yacc_dport_if #(
    parameter int unsigned AW = 15
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_wren;
    logic [31:0]   cpu_wdata;
    logic [1:0]    cpu_mode;
    logic          cpu_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata;
    logic [1:0]    host_mode;
`ifdef DPORT_BURST_EN
    logic [3:0]    host_len;
`endif
    logic          host_gnt;
    logic          host_err;
    logic          host_rvalid;
    logic [31:0]   host_rdata;

    logic [AW-1:0] ram_daddr;
    logic          ram_wren;
    logic [31:0]   ram_datain;
    logic [1:0]    ram_access_mode;
    logic [31:0]   ram_mout;

    modport slave (
`ifdef DPORT_BURST_EN
        input  host_len,
`endif
        input  cpu_req, cpu_addr, cpu_wren, cpu_wdata, cpu_mode,
        input  host_req, host_we, host_addr, host_wdata, host_mode,
        input  ram_mout,
        output cpu_stall, host_gnt, host_err, host_rvalid, host_rdata,
        output ram_daddr, ram_wren, ram_datain, ram_access_mode
    );

    modport master (
`ifdef DPORT_BURST_EN
        output host_len,
`endif
        output cpu_req, cpu_addr, cpu_wren, cpu_wdata, cpu_mode,
        output host_req, host_we, host_addr, host_wdata, host_mode,
        output ram_mout,
        input  cpu_stall, host_gnt, host_err, host_rvalid, host_rdata,
        input  ram_daddr, ram_wren, ram_datain, ram_access_mode
    );
endinterface

// File: rtl/yacc_dport_arbiter.sv
// Arbitrates the yacc RAM data port between the CPU (default owner) and one host requester,
// with a starvation counter forcing host slots. DPORT_BURST_EN enables LONG host bursts.
module yacc_dport_arbiter #(
    parameter int unsigned AW       = 15,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic         clock,
    input logic         sync_reset,
    yacc_dport_if.slave bus
);
    localparam logic [1:0] ModeLong = 2'b00;
    localparam logic [1:0] ModeWord = 2'b01;

    typedef enum logic [1:0] {StIdle, StHost, StBurst} state_e;

    state_e        state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          rvalid_q, rvalid_d;

    logic          aligned;
    logic          host_win;
    logic          gnt;
    logic          err;
    logic          use_host;
    logic [AW-1:0] host_daddr;
    logic          host_we_eff;
    logic [1:0]    host_mode_eff;
    logic          live;

`ifdef DPORT_BURST_EN
    logic [3:0]    beats_left_q, beats_left_d;
    logic [AW-1:0] burst_addr_q, burst_addr_d;
    logic          burst_we_q, burst_we_d;
`endif

    always_comb begin
        unique case (bus.host_mode)
            ModeLong: aligned = (bus.host_addr[1:0] == 2'b00);
            ModeWord: aligned = (bus.host_addr[0] == 1'b0);
            default:  aligned = 1'b1;
        endcase
    end

    assign host_win = !bus.cpu_req || (wait_cnt_q == 8'(MAX_WAIT));

    always_comb begin
        state_d       = StIdle;
        gnt           = 1'b0;
        err           = 1'b0;
        use_host      = 1'b0;
        host_daddr    = bus.host_addr;
        host_we_eff   = bus.host_we;
        host_mode_eff = bus.host_mode;
`ifdef DPORT_BURST_EN
        beats_left_d  = beats_left_q;
        burst_addr_d  = burst_addr_q;
        burst_we_d    = burst_we_q;
`endif
        unique case (state_q)
`ifdef DPORT_BURST_EN
            StBurst: begin
                // Host keeps the port for the remaining beats regardless of host_req.
                gnt           = 1'b1;
                use_host      = 1'b1;
                host_daddr    = burst_addr_q;
                host_we_eff   = burst_we_q;
                host_mode_eff = ModeLong;
                beats_left_d  = beats_left_q - 4'd1;
                burst_addr_d  = burst_addr_q + AW'(4);
                state_d       = (beats_left_q == 4'd1) ? StIdle : StBurst;
            end
`endif
            default: begin
                if (bus.host_req) begin
`ifdef DPORT_BURST_EN
                    if (!aligned || (bus.host_len != 4'd0 && bus.host_mode != ModeLong)) begin
                        err = 1'b1;
                    end else if (host_win) begin
                        gnt      = 1'b1;
                        use_host = 1'b1;
                        if (bus.host_len != 4'd0) begin
                            state_d      = StBurst;
                            beats_left_d = bus.host_len;
                            burst_addr_d = bus.host_addr + AW'(4);
                            burst_we_d   = bus.host_we;
                        end else begin
                            state_d = StHost;
                        end
                    end
`else
                    if (!aligned) begin
                        err = 1'b1;
                    end else if (host_win) begin
                        gnt      = 1'b1;
                        use_host = 1'b1;
                        state_d  = StHost;
                    end
`endif
                end
            end
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.host_req || gnt || err) begin
            wait_cnt_d = 8'd0;
        end else if (bus.cpu_req && wait_cnt_q < 8'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        rvalid_d = gnt && !host_we_eff;
    end

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 8'd0;
            rvalid_q     <= 1'b0;
`ifdef DPORT_BURST_EN
            beats_left_q <= 4'd0;
            burst_addr_q <= '0;
            burst_we_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            rvalid_q     <= rvalid_d;
`ifdef DPORT_BURST_EN
            beats_left_q <= beats_left_d;
            burst_addr_q <= burst_addr_d;
            burst_we_q   <= burst_we_d;
`endif
        end
    end

    // Outputs are masked during reset so a pending read response never escapes.
    assign live                = !sync_reset;
    assign bus.host_gnt        = gnt && live;
    assign bus.host_err        = err && live;
    assign bus.cpu_stall       = bus.cpu_req && use_host && live;
    assign bus.host_rvalid     = rvalid_q && live;
    assign bus.host_rdata      = bus.host_rvalid ? bus.ram_mout : 32'd0;
    assign bus.ram_daddr       = use_host ? host_daddr : bus.cpu_addr;
    assign bus.ram_wren        = live && (use_host ? host_we_eff : (bus.cpu_req && bus.cpu_wren));
    assign bus.ram_datain      = use_host ? bus.host_wdata : bus.cpu_wdata;
    assign bus.ram_access_mode = use_host ? host_mode_eff : bus.cpu_mode;
endmodule
